// File: rtl/issue_scheduler.sv
// issue_scheduler
//   Picks ready reservation-station entries and grants them to three
//   functional units: FU0/FU1 = ALU, FU2 = load/store. Grants, the
//   deallocate pulse and the busy flags are all registered.
//
//   clk, reset     : clock, synchronous active-high reset
//   rs_valid       : [RS_DEPTH] entry allocated
//   rs_ready       : [RS_DEPTH] source operands available
//   rs_is_mem      : [RS_DEPTH] 1 = load/store class, 0 = ALU class
//   stall          : no new grants this cycle
//   issue_valid    : [3] FU i received a grant (one-cycle pulse)
//   issue_idx_0..2 : [IDX_W] granted entry per FU, 0 when not valid
//   rs_clear       : [RS_DEPTH] OR of the granted entries (one-hot per grant)
//   func_units     : [3] FU busy flags

// Per-FU occupancy counter. Loads LAT-1 on the edge that registers a grant
// and counts down to zero; the FU is free again once it reads zero, which
// spaces successive grants exactly LAT edges apart.
module fu_busy_ctr #(
  parameter int LAT = 1,
  parameter int CW  = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic grant,
  output logic busy
);
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (grant)               cnt_d = CW'(LAT - 1);
    else if (cnt_q != '0)    cnt_d = cnt_q - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign busy = (cnt_q != '0);
endmodule

module issue_scheduler #(
  parameter int RS_DEPTH = 8,
  parameter int IDX_W    = $clog2(RS_DEPTH),
  parameter int ALU_LAT  = 1,
  parameter int MEM_LAT  = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [RS_DEPTH-1:0] rs_valid,
  input  logic [RS_DEPTH-1:0] rs_ready,
  input  logic [RS_DEPTH-1:0] rs_is_mem,
  input  logic                stall,
  output logic [2:0]          issue_valid,
  output logic [IDX_W-1:0]    issue_idx_0,
  output logic [IDX_W-1:0]    issue_idx_1,
  output logic [IDX_W-1:0]    issue_idx_2,
  output logic [RS_DEPTH-1:0] rs_clear,
  output logic [2:0]          func_units
);
  localparam int NUM_FU  = 3;
  localparam int MAX_LAT = (ALU_LAT > MEM_LAT) ? ALU_LAT : MEM_LAT;
  localparam int CW      = $clog2(MAX_LAT) + 1;

  typedef struct packed {
    logic             vld;
    logic [IDX_W-1:0] idx;
  } grant_t;

  grant_t [NUM_FU-1:0] gnt_d, gnt_q;
  logic   [RS_DEPTH-1:0] rs_clear_d, rs_clear_q;
  logic   [IDX_W-1:0]    rr_alu_d, rr_alu_q, rr_mem_d, rr_mem_q;
  logic   [NUM_FU-1:0]   fu_busy;

  logic [RS_DEPTH-1:0] elig, elig_alu, elig_mem;
  logic [IDX_W-1:0]    a0, a1, m0, e;
  logic                a0_v, a1_v, m0_v;

  // Occupancy counters, one per FU; FU2 uses the memory latency.
  for (genvar g = 0; g < NUM_FU; g++) begin : g_fu
    fu_busy_ctr #(
      .LAT ((g == 2) ? MEM_LAT : ALU_LAT),
      .CW  (CW)
    ) u_ctr (
      .clk   (clk),
      .reset (reset),
      .grant (gnt_d[g].vld),
      .busy  (fu_busy[g])
    );
  end

  always_comb begin
    // Entries cleared this cycle are still presented by the RS; mask them.
    elig     = rs_valid & rs_ready & ~rs_clear_q;
    elig_alu = elig & ~rs_is_mem;
    elig_mem = elig & rs_is_mem;

    // Rotating scan: first two ALU hits from rr_alu, first mem hit from rr_mem.
    a0 = '0; a1 = '0; m0 = '0; e = '0;
    a0_v = 1'b0; a1_v = 1'b0; m0_v = 1'b0;
    for (int k = 0; k < RS_DEPTH; k++) begin
      e = rr_alu_q + IDX_W'(k);
      if (elig_alu[e]) begin
        if (!a0_v)      begin a0 = e; a0_v = 1'b1; end
        else if (!a1_v) begin a1 = e; a1_v = 1'b1; end
      end
      e = rr_mem_q + IDX_W'(k);
      if (elig_mem[e] && !m0_v) begin m0 = e; m0_v = 1'b1; end
    end

    gnt_d    = '0;
    rr_alu_d = rr_alu_q;
    rr_mem_d = rr_mem_q;
    if (!stall) begin
      if (!fu_busy[0] && !fu_busy[1]) begin
        if (a0_v) begin
          gnt_d[0].vld = 1'b1; gnt_d[0].idx = a0; rr_alu_d = a0 + IDX_W'(1);
        end
        if (a1_v) begin
          gnt_d[1].vld = 1'b1; gnt_d[1].idx = a1; rr_alu_d = a1 + IDX_W'(1);
        end
      end else if (!fu_busy[0]) begin
        if (a0_v) begin
          gnt_d[0].vld = 1'b1; gnt_d[0].idx = a0; rr_alu_d = a0 + IDX_W'(1);
        end
      end else if (!fu_busy[1]) begin
        if (a0_v) begin
          gnt_d[1].vld = 1'b1; gnt_d[1].idx = a0; rr_alu_d = a0 + IDX_W'(1);
        end
      end
      if (!fu_busy[2] && m0_v) begin
        gnt_d[2].vld = 1'b1; gnt_d[2].idx = m0; rr_mem_d = m0 + IDX_W'(1);
      end
    end

    rs_clear_d = '0;
    for (int g = 0; g < NUM_FU; g++)
      if (gnt_d[g].vld) rs_clear_d[gnt_d[g].idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      gnt_q      <= '0;
      rs_clear_q <= '0;
      rr_alu_q   <= '0;
      rr_mem_q   <= '0;
    end else begin
      gnt_q      <= gnt_d;
      rs_clear_q <= rs_clear_d;
      rr_alu_q   <= rr_alu_d;
      rr_mem_q   <= rr_mem_d;
    end
  end

  assign issue_valid = {gnt_q[2].vld, gnt_q[1].vld, gnt_q[0].vld};
  assign issue_idx_0 = gnt_q[0].idx;
  assign issue_idx_1 = gnt_q[1].idx;
  assign issue_idx_2 = gnt_q[2].idx;
  assign rs_clear    = rs_clear_q;
  assign func_units  = fu_busy;
endmodule

// File: tb/tb_issue_scheduler.sv
// Bench for issue_scheduler (RS_DEPTH=8, ALU_LAT=1, MEM_LAT=3).
// Reference model: grant timestamps per FU and queues of eligible entries.
module tb_issue_scheduler;
  localparam int D = 8;
  localparam int W = 3;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [D-1:0] rs_valid = '0, rs_ready = '0, rs_is_mem = '0;
  logic         stall = 1'b0;
  logic [2:0]   issue_valid;
  logic [W-1:0] issue_idx_0, issue_idx_1, issue_idx_2;
  logic [D-1:0] rs_clear;
  logic [2:0]   func_units;

  issue_scheduler #(.RS_DEPTH(D), .IDX_W(W), .ALU_LAT(1), .MEM_LAT(3)) dut (
    .clk(clk), .reset(reset), .rs_valid(rs_valid), .rs_ready(rs_ready),
    .rs_is_mem(rs_is_mem), .stall(stall), .issue_valid(issue_valid),
    .issue_idx_0(issue_idx_0), .issue_idx_1(issue_idx_1),
    .issue_idx_2(issue_idx_2), .rs_clear(rs_clear), .func_units(func_units)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---- reference model ----
  int       lat [3] = '{1, 1, 3};
  int       gedge [3];      // edge number of last grant per FU
  int       edge_n = 0;
  int       rr_a = 0, rr_m = 0;
  logic [2:0]   m_iv = '0;
  int           m_idx [3];
  logic [D-1:0] m_clr = '0;
  logic [2:0]   m_fu = '0;

  // Advance the model across the coming edge using the current inputs.
  task automatic model_step();
    int n;
    int aq[$];
    int mq[$];
    int fl[$];
    int e, cnt;
    n = edge_n + 1;
    if (reset) begin
      rr_a = 0; rr_m = 0;
      for (int i = 0; i < 3; i++) begin gedge[i] = -100; m_idx[i] = 0; end
      m_iv = '0; m_clr = '0; m_fu = '0;
      edge_n = n;
      return;
    end
    m_iv = '0;
    for (int i = 0; i < 3; i++) m_idx[i] = 0;
    if (!stall) begin
      for (int k = 0; k < D; k++) begin
        e = (rr_a + k) % D;
        if (rs_valid[e] && rs_ready[e] && !m_clr[e] && !rs_is_mem[e]) aq.push_back(e);
        e = (rr_m + k) % D;
        if (rs_valid[e] && rs_ready[e] && !m_clr[e] && rs_is_mem[e]) mq.push_back(e);
      end
      for (int i = 0; i < 2; i++) if (n >= gedge[i] + lat[i]) fl.push_back(i);
      cnt = (fl.size() < aq.size()) ? fl.size() : aq.size();
      for (int j = 0; j < cnt; j++) begin
        m_iv[fl[j]] = 1'b1; m_idx[fl[j]] = aq[j]; gedge[fl[j]] = n;
      end
      if (cnt > 0) rr_a = (aq[cnt-1] + 1) % D;
      if (n >= gedge[2] + lat[2] && mq.size() > 0) begin
        m_iv[2] = 1'b1; m_idx[2] = mq[0]; gedge[2] = n; rr_m = (mq[0] + 1) % D;
      end
    end
    m_clr = '0;
    for (int i = 0; i < 3; i++) if (m_iv[i]) m_clr[m_idx[i]] = 1'b1;
    for (int i = 0; i < 3; i++) m_fu[i] = (n < gedge[i] + lat[i] - 1);
    edge_n = n;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    chk("issue_valid", 32'(issue_valid), 32'(m_iv));
    chk("idx0", 32'(issue_idx_0), 32'(m_idx[0]));
    chk("idx1", 32'(issue_idx_1), 32'(m_idx[1]));
    chk("idx2", 32'(issue_idx_2), 32'(m_idx[2]));
    chk("rs_clear", 32'(rs_clear), 32'(m_clr));
    chk("func_units", 32'(func_units), 32'(m_fu));
  endtask

  task automatic set_in(input logic [D-1:0] v, input logic [D-1:0] r,
                        input logic [D-1:0] m, input logic s);
    rs_valid = v; rs_ready = r; rs_is_mem = m; stall = s;
  endtask

  initial begin
    // 1: reset with everything ready
    set_in(8'hFF, 8'hFF, 8'h0F, 1'b0);
    reset = 1'b1;
    tick(); chk("rst_iv", 32'(issue_valid), 0); chk("rst_fu", 32'(func_units), 0);
    tick(); chk("rst_clr", 32'(rs_clear), 0);
    reset = 1'b0;
    tick(); chk("post_rst_iv", 32'(issue_valid), 32'h7);

    // 2: dual ALU grant, then masked
    reset = 1'b1; tick(); reset = 1'b0;
    set_in(8'h24, 8'h24, 8'h00, 1'b0);
    tick();
    chk("dual_iv", 32'(issue_valid), 32'h3);
    chk("dual_i0", 32'(issue_idx_0), 2);
    chk("dual_i1", 32'(issue_idx_1), 5);
    chk("dual_clr", 32'(rs_clear), 32'h24);
    tick(); chk("masked_iv", 32'(issue_valid), 0);

    // 3: wrap-around from rr_alu = 6
    set_in(8'h82, 8'h82, 8'h00, 1'b0);
    tick();
    chk("wrap_i0", 32'(issue_idx_0), 7);
    chk("wrap_i1", 32'(issue_idx_1), 1);

    // 4: LSU latency, entries 3 and 4 held
    reset = 1'b1; tick(); reset = 1'b0;
    set_in(8'h18, 8'h18, 8'h18, 1'b0);
    tick(); chk("lsu_e1", 32'({issue_valid[2], issue_idx_2}), 32'h0B);
    chk("lsu_busy1", 32'(func_units[2]), 1);
    tick(); chk("lsu_busy2", 32'(func_units[2]), 1);
    tick(); chk("lsu_free", 32'(func_units[2]), 0);
    chk("lsu_e3_none", 32'(issue_valid[2]), 0);
    tick(); chk("lsu_e4", 32'({issue_valid[2], issue_idx_2}), 32'h0C);
    // 5: stall while FU2 is mid-busy, then the case-2 pattern
    set_in(8'h24, 8'h24, 8'h00, 1'b1);
    repeat (3) begin tick(); chk("stall_iv", 32'(issue_valid), 0); end
    stall = 1'b0;
    tick(); chk("unstall_iv", 32'(issue_valid), 32'h3);
    chk("unstall_i0", 32'(issue_idx_0), 2);

    // 6: class / readiness filter
    reset = 1'b1; tick(); reset = 1'b0;
    set_in(8'h07, 8'h05, 8'h01, 1'b0);
    tick();
    chk("filt_iv", 32'(issue_valid), 32'h5);
    chk("filt_i0", 32'(issue_idx_0), 2);
    chk("filt_i2", 32'(issue_idx_2), 0);
    repeat (4) begin tick(); chk("filt_no1", 32'(rs_clear[1]), 0); end

    // random traffic against the model
    for (int c = 0; c < 3000; c++) begin
      set_in(D'($urandom), D'($urandom | $urandom), D'($urandom),
             ($urandom_range(0, 4) == 0));
      reset = ($urandom_range(0, 99) == 0);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
